rr_gate_arbiter: RTL and testbench
==================================

RR_GATE_ARBITER -- requirements
Module: rr_gate_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 64: maximum number of cycles a grant is held before forced release; legal range 2..255.
REQ-002 clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request lines, bit i = requester i; a requester holds its bit high for as long as it uses the resource.
REQ-005 gnt  output  4  registered grant, one-hot or zero.
REQ-006 owner  output  2  index of the current or most recent grantee.
REQ-007 busy  output  1  high whenever gnt is nonzero.
REQ-008 tmo  output  1  one-cycle pulse on forced release.

Function
REQ-009 The state machine SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-010 In IDLE or GAP with any effective request, the next state SHALL be GRANT, and the winner's gnt bit SHALL rise on the next edge (1-cycle request-to-grant latency).
REQ-011 In IDLE with no effective request, the state SHALL remain IDLE; in GAP with no effective request, the next state SHALL be IDLE.
REQ-012 The winner SHALL be the first requester with an effective request, scanning rr_ptr, rr_ptr+1, ... modulo 4.
REQ-013 rr_ptr SHALL load winner+1 (2-bit wrap, 3->0) in the cycle the grant is issued.
REQ-014 In GRANT, gnt SHALL stay constant while req[owner]=1; changes on other req bits SHALL have no effect.
REQ-015 When req[owner]=0 is sampled in GRANT, gnt SHALL be 0 on the next edge and the state SHALL move to GAP, giving exactly one grant-free cycle between owners.
REQ-016 A requester that deasserts and reasserts req in the same GAP cycle SHALL be treated as a new request with round-robin priority.
REQ-017 owner SHALL hold its last value while in IDLE and GAP.
REQ-018 busy SHALL be combinationally equal to the OR of the gnt bits.
REQ-019 A request is effective when its req bit is 1 and it is not locked out (REQ-027).

Reset
REQ-020 While reset=1 at a rising edge, the block SHALL load: state=IDLE, gnt=0000, owner=00, rr_ptr=00, tmo=0, timeout counter=0 and all lockouts clear.
REQ-021 Reset asserted during GRANT SHALL drop gnt on that same edge, with no GAP cycle and no tmo pulse.
REQ-022 On the first edge after reset deasserts, arbitration SHALL start with requester 0 at highest priority.

Configuration
REQ-023 The timeout feature SHALL be controlled by the macro RR_GATE_ARBITER_TIMEOUT_EN.
REQ-024 With the macro defined, an 8-bit counter SHALL clear on grant issue and increment on each cycle spent in GRANT.
REQ-025 With the macro defined, when the counter reaches TMO_CYCLES-1 while req[owner]=1, the next edge SHALL set gnt=0 and state=GAP, and tmo=1 for one cycle.
REQ-026 With the macro defined, a release on the same cycle the limit is reached SHALL be a normal release: no tmo pulse and no lockout.
REQ-027 With the macro defined, a timed-out requester SHALL be locked out until its req has been sampled 0 for at least one cycle.
REQ-028 Without the macro, the block SHALL contain no counter and no lockout logic, tmo SHALL be tied to 0, and grants SHALL be held indefinitely.

Verification
REQ-029 Reset, then req=0001 at cycle 0 -> gnt=0001 and owner=0 at cycle 1; req=0000 at cycle 5 -> gnt=0000 at cycle 6 (GAP), state IDLE at cycle 7.
REQ-030 req=1111 held, each owner releases after 3 cycles in GRANT -> grant order 0,1,2,3,0 with exactly one gnt=0000 cycle between grants.
REQ-031 Owner 2 active and req=1011 when 2 releases -> next grant goes to 3, then to 0.
REQ-032 Reset asserted while gnt=0100 -> gnt=0000 on the next edge; with req=1111 afterwards, the first grant goes to 0.
REQ-033 Macro defined, TMO_CYCLES=4, req=0010 held -> gnt=0010 for 4 cycles, then gnt=0000 with tmo=1; requester 1 gets no grant until req[1] has been low for one cycle.
REQ-034 Macro undefined, same stimulus as REQ-033 -> gnt=0010 held for 1000 cycles and tmo stays 0.

Source files
------------

// File: rtl/rr_gate_arbiter_if.sv
// rr_gate_arbiter_if: request/grant bundle between requesters and rr_gate_arbiter.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the resource. The arbiter answers with a registered, one-hot gnt[i].
// The owner releases by dropping req[i]. gnt then falls on the next edge, and
// one grant-free cycle follows before any other owner is granted.
// state_dbg mirrors the arbiter FSM state (0=IDLE, 1=GRANT, 2=GAP) so that
// checkers can bind to it.
interface rr_gate_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       tmo;
  logic [1:0] state_dbg;

  // Requester side: drives req and observes the arbiter outputs.
  modport master (
    output req,
    input  gnt,
    input  owner,
    input  busy,
    input  tmo,
    input  state_dbg
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output owner,
    output busy,
    output tmo,
    output state_dbg
  );
endinterface

// File: rtl/rr_gate_arbiter.sv
// rr_gate_arbiter: 4-way round-robin arbiter with a one-cycle gap between owners.
//
// A grant is held for as long as the owner keeps its req bit high. When the
// owner drops it, the arbiter spends exactly one GAP cycle with gnt=0 before
// granting again. Priority rotates: after requester i is granted, the scan
// starts at i+1.
//
// Optional feature, macro RR_GATE_ARBITER_TIMEOUT_EN:
//   An 8-bit counter limits a grant to TMO_CYCLES cycles. When the limit is
//   reached, the grant is forced off with a one-cycle tmo pulse, and the
//   requester is locked out until its req has been seen low. Without the
//   macro, grants are held indefinitely and tmo is tied low.
module rr_gate_arbiter #(
  parameter int unsigned TMO_CYCLES = 64
) (
  input logic              clk,
  input logic              reset,
  rr_gate_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Reject out-of-range limits at elaboration time. The counter is 8 bits,
  // and a limit below 2 would leave no room for a normal release.
  if (TMO_CYCLES < 2 || TMO_CYCLES > 255) begin : g_bad_tmo_cycles
    $error("rr_gate_arbiter: TMO_CYCLES must be in 2..255");
  end

  state_t     state;
  logic [3:0] gnt_q;
  logic [1:0] owner_q;
  logic [1:0] rr_ptr;

  logic [3:0] eff_req;
  logic       any_eff;
  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       owner_req;

  assign owner_req = bus.req[owner_q];

`ifdef RR_GATE_ARBITER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic [3:0] lock;
  logic       tmo_q;
  logic       limit_hit;

  // A locked-out requester is invisible to the scan until it has dropped req.
  assign eff_req   = bus.req & ~lock;
  // The limit forces a release only while the owner still wants the resource.
  // A voluntary release in the same cycle takes precedence as a normal release.
  assign limit_hit = (tmo_cnt == 8'(TMO_CYCLES - 1));
  assign bus.tmo   = tmo_q;
`else
  assign eff_req   = bus.req;
  assign bus.tmo   = 1'b0;
`endif

  // Round-robin scan: the first effective request at rr_ptr, rr_ptr+1, ... wins.
  // The loop runs from the farthest offset down, so the closest match is
  // assigned last and wins.
  always_comb begin
    winner   = rr_ptr;
    any_eff  = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr + 2'(k);
      if (eff_req[scan_idx]) begin
        winner  = scan_idx;
        any_eff = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant, owner, pointer and (optional) timeout state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      rr_ptr  <= 2'd0;
`ifdef RR_GATE_ARBITER_TIMEOUT_EN
      tmo_cnt <= 8'd0;
      lock    <= 4'b0000;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_GATE_ARBITER_TIMEOUT_EN
      tmo_q <= 1'b0;
      // Any lockout clears once its req has been sampled low.
      lock  <= lock & bus.req;
`endif
      case (state)
        IDLE, GAP: begin
          if (any_eff) begin
            state   <= GRANT;
            gnt_q   <= 4'b0001 << winner;
            owner_q <= winner;
            rr_ptr  <= winner + 2'd1;
`ifdef RR_GATE_ARBITER_TIMEOUT_EN
            tmo_cnt <= 8'd0;
`endif
          end else if (state == GAP) begin
            state <= IDLE;
          end
        end

        GRANT: begin
          if (!owner_req) begin
            // Voluntary release: one grant-free cycle follows.
            state <= GAP;
            gnt_q <= 4'b0000;
`ifdef RR_GATE_ARBITER_TIMEOUT_EN
          end else if (limit_hit) begin
            // Forced release: pulse tmo and lock the owner out.
            state          <= GAP;
            gnt_q          <= 4'b0000;
            tmo_q          <= 1'b1;
            lock[owner_q]  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end

        default: begin
          state <= IDLE;
          gnt_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = |gnt_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// tb_rr_gate_arbiter: table-driven bench for rr_gate_arbiter (TMO_CYCLES=4).
// Each table row is one clock cycle: inputs are applied, one edge passes, and
// the outputs are compared. Hand-written sequences cover the timeout and the
// long hold. Both builds, with and without RR_GATE_ARBITER_TIMEOUT_EN, are covered.
module tb_rr_gate_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [1:0] st;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  rr_gate_arbiter_if bus_if ();

  rr_gate_arbiter #(.TMO_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare
  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                     input logic [1:0] owner, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.owner = owner; v.st = st;
    vecs.push_back(v);
  endtask

  // Driver: apply inputs, wait one edge, sample 1 time unit later
  task automatic step(input logic rst, input logic [3:0] req);
    reset      = rst;
    bus_if.req = req;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] gnt,
                           input logic [1:0] owner, input logic [1:0] st,
                           input logic tmo);
    check({tag, "_gnt"},   idx, 32'(bus_if.gnt),       32'(gnt));
    check({tag, "_owner"}, idx, 32'(bus_if.owner),     32'(owner));
    check({tag, "_state"}, idx, 32'(bus_if.state_dbg), 32'(st));
    check({tag, "_busy"},  idx, 32'(bus_if.busy),      32'(gnt != 4'b0000));
    check({tag, "_tmo"},   idx, 32'(bus_if.tmo),       32'(tmo));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus_if.req = 4'b0000;

    // Reset state
    add(1, 4'b0000, 4'b0000, 0, S_IDLE);
    add(1, 4'b0000, 4'b0000, 0, S_IDLE);
    // Single requester: one-cycle grant latency, release, GAP, then IDLE.
    // The release lands on the counter-limit cycle, so it is a normal release.
    add(0, 4'b0001, 4'b0001, 0, S_GRANT);
    add(0, 4'b0001, 4'b0001, 0, S_GRANT);
    add(0, 4'b0001, 4'b0001, 0, S_GRANT);
    add(0, 4'b0001, 4'b0001, 0, S_GRANT);
    add(0, 4'b0000, 4'b0000, 0, S_GAP);
    add(0, 4'b0000, 4'b0000, 0, S_IDLE);
    // Reset restarts priority at 0 (reset wins over pending requests)
    add(1, 4'b1111, 4'b0000, 0, S_IDLE);
    // All requesting: order 0,1,2,3,0 with one gap cycle each
    add(0, 4'b1111, 4'b0001, 0, S_GRANT);
    add(0, 4'b1111, 4'b0001, 0, S_GRANT);
    add(0, 4'b1111, 4'b0001, 0, S_GRANT);
    add(0, 4'b1110, 4'b0000, 0, S_GAP);
    add(0, 4'b1111, 4'b0010, 1, S_GRANT);  // 0 re-requests in GAP: 1 still wins
    add(0, 4'b1111, 4'b0010, 1, S_GRANT);
    add(0, 4'b1111, 4'b0010, 1, S_GRANT);
    add(0, 4'b1101, 4'b0000, 1, S_GAP);
    add(0, 4'b1111, 4'b0100, 2, S_GRANT);
    add(0, 4'b1111, 4'b0100, 2, S_GRANT);
    add(0, 4'b1111, 4'b0100, 2, S_GRANT);
    add(0, 4'b1011, 4'b0000, 2, S_GAP);
    add(0, 4'b1111, 4'b1000, 3, S_GRANT);
    add(0, 4'b1111, 4'b1000, 3, S_GRANT);
    add(0, 4'b1111, 4'b1000, 3, S_GRANT);
    add(0, 4'b0111, 4'b0000, 3, S_GAP);
    add(0, 4'b1111, 4'b0001, 0, S_GRANT);
    // Other req bits changing during a grant have no effect
    add(0, 4'b0101, 4'b0001, 0, S_GRANT);
    add(0, 4'b1001, 4'b0001, 0, S_GRANT);
    add(0, 4'b1110, 4'b0000, 0, S_GAP);
    // Owner 2 releases with req=1011: next grant goes to 3, then to 0
    add(0, 4'b1110, 4'b0010, 1, S_GRANT);
    add(0, 4'b1100, 4'b0000, 1, S_GAP);
    add(0, 4'b1111, 4'b0100, 2, S_GRANT);
    add(0, 4'b1111, 4'b0100, 2, S_GRANT);
    add(0, 4'b1011, 4'b0000, 2, S_GAP);
    add(0, 4'b1011, 4'b1000, 3, S_GRANT);
    add(0, 4'b1011, 4'b1000, 3, S_GRANT);
    add(0, 4'b0011, 4'b0000, 3, S_GAP);
    add(0, 4'b0011, 4'b0001, 0, S_GRANT);
    // Reset during GRANT drops gnt at once; the first grant afterwards goes to 0
    add(0, 4'b0100, 4'b0000, 0, S_GAP);
    add(0, 4'b0100, 4'b0100, 2, S_GRANT);
    add(1, 4'b0100, 4'b0000, 0, S_IDLE);
    add(0, 4'b1111, 4'b0001, 0, S_GRANT);
    // Owner is held through GAP and IDLE
    add(0, 4'b0000, 4'b0000, 0, S_GAP);
    add(0, 4'b0000, 4'b0000, 0, S_IDLE);
    add(0, 4'b0000, 4'b0000, 0, S_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req);
      check_all("tbl", i, vecs[i].gnt, vecs[i].owner, vecs[i].st, 1'b0);
    end

    // Long-hold sequence: reset, then req=0010 held
    step(1, 4'b0000);
    check_all("seq_rst", 0, 4'b0000, 0, S_IDLE, 1'b0);
`ifdef RR_GATE_ARBITER_TIMEOUT_EN
    // gnt for 4 cycles, forced release with tmo, lockout while req stays high
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b0010);
      check_all("tmo_hold", i, 4'b0010, 1, S_GRANT, 1'b0);
    end
    step(0, 4'b0010);
    check_all("tmo_fire", 0, 4'b0000, 1, S_GAP, 1'b1);
    step(0, 4'b0010);
    check_all("tmo_lock", 0, 4'b0000, 1, S_IDLE, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(0, 4'b0010);
      check_all("tmo_lock", i, 4'b0000, 1, S_IDLE, 1'b0);
    end
    // req low for one cycle clears the lockout
    step(0, 4'b0000);
    check_all("tmo_drop", 0, 4'b0000, 1, S_IDLE, 1'b0);
    step(0, 4'b0010);
    check_all("tmo_regrant", 0, 4'b0010, 1, S_GRANT, 1'b0);
`else
    // Without the timeout feature the grant is held indefinitely
    for (int i = 0; i < 1000; i++) begin
      step(0, 4'b0010);
      check_all("nohold", i, 4'b0010, 1, S_GRANT, 1'b0);
    end
`endif
    step(0, 4'b0000);
    check_all("seq_end", 0, 4'b0000, 1, S_GAP, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
